lc3b_scoreboard: RTL and testbench
==================================

# lc3b_scoreboard

Parametrised hazard scoreboard for the LC-3b pipeline, sitting between decode and execute. It generalises the fixed two-way `lc3b_forward` select (none / ex_ex / mem_ex) to any number of post-decode stages and any number of source operands. It tracks in-flight destination registers in a shift register that advances with the pipeline. Each cycle it produces, per decode source operand, a forwarding select naming the youngest producing stage, plus a load-use stall request.

## Interface
- `NUM_STAGES`, default 3: tracked stages after decode; stage 0 = EX, stage 1 = MEM, stage NUM_STAGES-1 = WB. Legal range 2..7.
- `NUM_SRC`, default 2: source operands checked per decoded instruction.
- `REG_W`, default 3: register index width (lc3b_reg).
- `SEL_W`, derived: $clog2(NUM_STAGES+1). Not user-set.

- `clk` in, 1: single clock; all state updates on its rising edge.
- `reset` in, 1: asynchronous, active-high; clears all state immediately.
- `id_valid` in, 1: decode stage holds a real instruction.
- `id_dest_valid` in, 1: that instruction writes a register.
- `id_dest` in, REG_W: destination register.
- `id_is_load` in, 1: the result is produced in MEM (LDR/LDB/LDI), not in EX.
- `id_src` in, NUM_SRC*REG_W: source registers; operand i is at bits [i*REG_W +: REG_W].
- `id_src_valid` in, NUM_SRC: per-operand "operand is read" flag.
- `advance` in, 1: pipeline enable; 0 while memory holds the pipe.
- `flush` in, 1: branch/trap redirect; kills the decode instruction and the EX entry.
- `stall_out` out, 1: load-use hazard; decode must hold.
- `fwd_sel` out, NUM_SRC*SEL_W: per operand, 0 = register file, k = forward from stage k-1.

## Operation
- State: `NUM_STAGES` entries s[0..N-1], each holding {valid, dest, is_load}.
- Match rule: operand i matches s[k] when id_src_valid[i], s[k].valid, and s[k].dest == id_src[i].
- fwd_sel[i] = k+1 for the lowest matching k (youngest producer wins); otherwise 0.
- fwd_sel is computed regardless of id_valid.
- stall_out = id_valid & !flush & (some operand i matches s[0] with s[0].is_load).
- fwd_sel still reports 1 for that operand while the stall is active.
- A load in s[1] or later forwards normally without a stall.
- Update priority, on each rising edge:
  - `advance`=0 and `flush`=0: all entries hold.
  - `advance`=0 and `flush`=1: s[0].valid <= 0; the other entries hold.
  - `advance`=1: s[k] <= s[k-1] for k≥1. s[0] <= a bubble if flush or stall_out; otherwise {id_valid & id_dest_valid, id_dest, id_is_load}.
- s[N-1] is dropped on shift-out; the register file is written at the end of that cycle.
- There is no R0 special case; all 8 registers are real.

## Timing
- Reset: every s[k].valid = 0. Therefore fwd_sel = 0 and stall_out = 0, and the stall counter is 0 when built.
- stall_out and fwd_sel are combinational from the entries plus the id_* and flush inputs. They are valid in the same cycle, with no added latency.
- An instruction captured at edge T is visible as s[0] from T onward. It forwards from stage k during the k-th advancing cycle after capture.
- A load-use stall lasts exactly one advancing cycle: the bubble pushes the load to s[1], which clears the hazard.
- If advance=0, the stall persists until advance returns.
- If reset is asserted mid-operation, all in-flight entries are discarded asynchronously. Deassertion is synchronous to clk at the system level.

## Configuration
- `LC3B_SCOREBOARD_PERF_EN` defined: adds output `stall_count` (out, 16). It increments on each edge where stall_out & advance, saturates at 16'hFFFF, and is cleared by reset.
- Macro absent: the port and the counter do not exist; all other behaviour is identical.

## Test plan
- Reset with id_valid=1, id_src={R2,R1}, all src_valid=1 -> stall_out=0, fwd_sel={0,0}. Release reset; no entries are valid.
- ADD R3 captured with advance=1, next instruction reads R3 as operand 0 -> fwd_sel[0]=1. After one more advance, fwd_sel[0]=2; after the third, 3; after the fourth, 0.
- LDR R4 captured, next instruction reads R4 -> stall_out=1 for one cycle, a bubble enters s[0], then fwd_sel=2 and stall_out=0. With PERF_EN, stall_count=1.
- ADD R5 captured at T, then ADD R5 captured at T+1, reader at T+2 -> fwd_sel=1 (youngest wins), not 2.
- Same load-use scenario with advance=0 for 3 cycles -> stall_out stays 1 and the entries hold. The counter does not increment until advance=1.
- ADD R6 in s[0], flush=1 with advance=0 -> s[0] invalidated. A reader of R6 then sees fwd_sel=0. A simultaneous id instruction is not captured.

Source files
------------

// File: rtl/lc3b_scoreboard.sv
// rtl/lc3b_scoreboard.sv - LC-3b decode/execute hazard scoreboard with per-operand forwarding selects and load-use stall.
// Optional stall counter output enabled by defining LC3B_SCOREBOARD_PERF_EN.
module lc3b_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int REG_W      = 3,
    localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic                     id_dest_valid,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_is_load,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_valid,
    input  logic                     advance,
    input  logic                     flush,
`ifdef LC3B_SCOREBOARD_PERF_EN
    output logic [15:0]              stall_count,
`endif
    output logic                     stall_out,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel
);

    logic [NUM_STAGES-1:0]            valid_q, valid_d;
    logic [NUM_STAGES-1:0]            load_q,  load_d;
    logic [NUM_STAGES-1:0][REG_W-1:0] dest_q,  dest_d;
    logic                             load_hit;

    // Descending scan so the lowest (youngest) matching stage is written last and wins.
    always_comb begin
        fwd_sel  = '0;
        load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (id_src_valid[i] && valid_q[k] &&
                    (dest_q[k] == id_src[i*REG_W +: REG_W])) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
            if (id_src_valid[i] && valid_q[0] && load_q[0] &&
                (dest_q[0] == id_src[i*REG_W +: REG_W])) begin
                load_hit = 1'b1;
            end
        end
        stall_out = id_valid && !flush && load_hit;
    end

    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        dest_d  = dest_q;
        if (advance) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                dest_d[k]  = dest_q[k-1];
            end
            // A stalled or flushed decode slot enters EX as a bubble.
            if (flush || stall_out) begin
                valid_d[0] = 1'b0;
                load_d[0]  = 1'b0;
                dest_d[0]  = '0;
            end else begin
                valid_d[0] = id_valid && id_dest_valid;
                load_d[0]  = id_is_load;
                dest_d[0]  = id_dest;
            end
        end else if (flush) begin
            valid_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            load_q  <= '0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            dest_q  <= dest_d;
        end
    end

`ifdef LC3B_SCOREBOARD_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_out && advance && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// tb/tb_lc3b_scoreboard.sv - Scoreboard-checked directed bench for lc3b_scoreboard (default parameters).
module tb_lc3b_scoreboard;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic       id_dest_valid;
    logic [2:0] id_dest;
    logic       id_is_load;
    logic [5:0] id_src;
    logic [1:0] id_src_valid;
    logic       advance;
    logic       flush;
    logic       stall_out;
    logic [3:0] fwd_sel;
`ifdef LC3B_SCOREBOARD_PERF_EN
    logic [15:0] stall_count;
`endif

    lc3b_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_dest_valid (id_dest_valid),
        .id_dest       (id_dest),
        .id_is_load    (id_is_load),
        .id_src        (id_src),
        .id_src_valid  (id_src_valid),
        .advance       (advance),
        .flush         (flush),
`ifdef LC3B_SCOREBOARD_PERF_EN
        .stall_count   (stall_count),
`endif
        .stall_out     (stall_out),
        .fwd_sel       (fwd_sel)
    );

    typedef struct {
        logic        stall;
        logic [1:0]  f1;
        logic [1:0]  f0;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall_out !== e.stall) begin
                errors++;
                $display("FAIL %s stall_out got %0b exp %0b", e.name, stall_out, e.stall);
            end
            checks++;
            if (fwd_sel[1:0] !== e.f0) begin
                errors++;
                $display("FAIL %s fwd_sel[0] got %0d exp %0d", e.name, fwd_sel[1:0], e.f0);
            end
            checks++;
            if (fwd_sel[3:2] !== e.f1) begin
                errors++;
                $display("FAIL %s fwd_sel[1] got %0d exp %0d", e.name, fwd_sel[3:2], e.f1);
            end
`ifdef LC3B_SCOREBOARD_PERF_EN
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count got %0d exp %0d", e.name, stall_count, e.cnt);
            end
`endif
        end
    end

    // Drive one cycle of inputs and queue the hand-computed response for it.
    task automatic cyc(input logic v, input logic dv, input logic [2:0] d, input logic ld,
                       input logic [2:0] s1, input logic [2:0] s0, input logic [1:0] sv,
                       input logic adv, input logic fl,
                       input logic est, input logic [1:0] ef1, input logic [1:0] ef0,
                       input string name);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid      = v;
        id_dest_valid = dv;
        id_dest       = d;
        id_is_load    = ld;
        id_src        = {s1, s0};
        id_src_valid  = sv;
        advance       = adv;
        flush         = fl;
        e.stall = est;
        e.f1    = ef1;
        e.f0    = ef0;
        e.cnt   = exp_cnt;
        e.name  = name;
        exp_q.push_back(e);
        if (est && adv && !reset && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_dest_valid = 0; id_dest = 0; id_is_load = 0;
        id_src = 0; id_src_valid = 0; advance = 0; flush = 0;

        //   v  dv d  ld s1 s0 sv     adv fl  st f1 f0
        cyc(1, 1, 7, 0, 2, 1, 2'b11, 0, 0,  0, 0, 0, "reset");
        reset = 1'b0;
        cyc(0, 0, 0, 0, 2, 1, 2'b11, 1, 0,  0, 0, 0, "post_reset");
        cyc(1, 1, 3, 0, 0, 0, 2'b00, 1, 0,  0, 0, 0, "add_r3_issue");
        cyc(1, 0, 0, 0, 0, 3, 2'b01, 1, 0,  0, 0, 1, "fwd_ex");
        cyc(1, 0, 0, 0, 0, 3, 2'b01, 1, 0,  0, 0, 2, "fwd_mem");
        cyc(1, 0, 0, 0, 0, 3, 2'b01, 1, 0,  0, 0, 3, "fwd_wb");
        cyc(1, 0, 0, 0, 0, 3, 2'b01, 1, 0,  0, 0, 0, "fwd_retired");
        cyc(1, 1, 4, 1, 0, 0, 2'b00, 1, 0,  0, 0, 0, "ldr_issue");
        cyc(1, 1, 1, 0, 0, 4, 2'b01, 1, 0,  1, 0, 1, "load_use_stall");
        cyc(1, 1, 1, 0, 0, 4, 2'b01, 1, 0,  0, 0, 2, "after_stall");
        cyc(1, 0, 0, 0, 1, 4, 2'b11, 1, 0,  0, 1, 3, "two_operands");
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 0,  0, 0, 0, "drain_a");
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 0,  0, 0, 0, "drain_b");
        cyc(1, 1, 5, 0, 0, 0, 2'b00, 1, 0,  0, 0, 0, "add_r5_a");
        cyc(1, 1, 5, 0, 5, 0, 2'b10, 1, 0,  0, 1, 0, "add_r5_b");
        cyc(1, 0, 0, 0, 0, 5, 2'b01, 1, 0,  0, 0, 1, "youngest_wins");
        cyc(1, 0, 0, 0, 0, 5, 2'b01, 1, 0,  0, 0, 2, "older_pair");
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 0,  0, 0, 0, "drain_c");
        cyc(1, 1, 2, 1, 0, 0, 2'b00, 1, 0,  0, 0, 0, "ldr2_issue");
        cyc(1, 1, 6, 0, 0, 2, 2'b01, 0, 0,  1, 0, 1, "hold_stall_0");
        cyc(1, 1, 6, 0, 0, 2, 2'b01, 0, 0,  1, 0, 1, "hold_stall_1");
        cyc(1, 1, 6, 0, 0, 2, 2'b01, 0, 0,  1, 0, 1, "hold_stall_2");
        cyc(1, 1, 6, 0, 0, 2, 2'b01, 1, 0,  1, 0, 1, "hold_release");
        cyc(1, 1, 6, 0, 0, 2, 2'b01, 1, 0,  0, 0, 2, "after_release");
        cyc(1, 1, 7, 0, 0, 6, 2'b01, 0, 1,  0, 0, 1, "flush_cycle");
        cyc(1, 0, 0, 0, 7, 6, 2'b11, 0, 0,  0, 0, 0, "flushed_reader");
        cyc(1, 0, 0, 0, 2, 0, 2'b10, 0, 0,  0, 3, 0, "flush_holds_wb");
        cyc(1, 1, 1, 1, 0, 0, 2'b00, 1, 0,  0, 0, 0, "ldr3_issue");
        cyc(1, 0, 0, 0, 0, 1, 2'b01, 1, 1,  0, 0, 1, "flush_masks_stall");
        cyc(1, 0, 0, 0, 0, 1, 2'b01, 1, 0,  0, 0, 2, "load_in_mem");
        cyc(0, 0, 0, 0, 0, 1, 2'b01, 1, 0,  0, 0, 3, "load_in_wb");

        for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
